// File: rtl/lsu_mem_sequencer.sv
// In-order load/store sequencer: request queue -> single data-bus access -> completion.
// Define LSU_SKID_QUEUE_EN for a 2-entry queue (one request may wait behind the one in flight).
module lsu_mem_sequencer #(
  parameter  int NUM_CB_ENTRY = 16,
  localparam int IDXW         = $clog2(NUM_CB_ENTRY)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic            req_dren,
  input  logic            req_dwen,
  input  logic [2:0]      req_load_type,
  input  logic [4:0]      req_rd,
  input  logic            req_wen,
  input  logic [IDXW-1:0] req_index,
  input  logic            flush,
  output logic [31:0]     dmem_addr,
  output logic            dmem_ren,
  output logic            dmem_wen,
  output logic [31:0]     dmem_wdata,
  output logic [3:0]      dmem_byte_en,
  input  logic [31:0]     dmem_rdata,
  input  logic            dmem_busy,
  output logic            cpl_valid,
  input  logic            cpl_ready,
  output logic [IDXW-1:0] cpl_index,
  output logic [4:0]      cpl_rd,
  output logic            cpl_wen,
  output logic [31:0]     cpl_data,
  output logic            cpl_exc,
  output logic [3:0]      cpl_cause
);

`ifdef LSU_SKID_QUEUE_EN
  localparam int Q = 2;
`else
  localparam int Q = 1;
`endif
  localparam int PW = (Q > 1) ? $clog2(Q) : 1;

  typedef struct packed {
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic            store;
    logic [2:0]      ltype;
    logic [4:0]      rd;
    logic            wen;
    logic [IDXW-1:0] index;
  } req_t;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  state_t state, state_nxt;

  req_t            q_mem [2**PW];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [1:0]      count;
  logic            inflight;

  logic            cur_store, cur_wen;
  logic [2:0]      cur_ltype;
  logic [1:0]      cur_off;
  logic [4:0]      cur_rd;
  logic [IDXW-1:0] cur_index;

  logic            push, pop, start_acc, start_exc, acc_done;
  logic            have_cand, cand_mis;
  req_t            inc, cand;
  logic [1:0]      cand_sz;
  logic [3:0]      cand_be;
  logic [31:0]     cand_wd, ld_shift, ld_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Q-1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy counts the popped-but-uncompleted access so a held completion still blocks intake.
  assign req_ready = ({1'b0, count} + {2'b0, inflight}) < 3'(Q);
  assign push      = req_valid && req_ready && !flush;

  assign inc = '{addr: req_addr, wdata: req_wdata, store: req_dwen && !req_dren,
                 ltype: req_load_type, rd: req_rd, wen: req_wen, index: req_index};

  // An empty queue bypasses the incoming request so the bus sees it the next cycle.
  assign have_cand = (count != 2'd0) || push;
  assign cand      = (count != 2'd0) ? q_mem[rd_ptr] : inc;
  assign cand_sz   = cand.ltype[1:0];
  assign cand_mis  = (cand_sz == 2'd1) ? cand.addr[0]
                   : (cand_sz[1] ? (cand.addr[1:0] != 2'b00) : 1'b0);

  always_comb begin
    cand_be = 4'b1111;
    cand_wd = cand.wdata;
    if (cand_sz == 2'd0) begin
      cand_be = 4'b0001 << cand.addr[1:0];
      cand_wd = {4{cand.wdata[7:0]}};
    end else if (cand_sz == 2'd1) begin
      cand_be = 4'b0011 << cand.addr[1:0];
      cand_wd = {2{cand.wdata[15:0]}};
    end
  end

  assign ld_shift = dmem_rdata >> {cur_off, 3'b000};
  always_comb begin
    ld_data = ld_shift;
    case (cur_ltype)
      3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'd1:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'd4:    ld_data = {24'b0, ld_shift[7:0]};
      3'd5:    ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    start_acc = 1'b0;
    start_exc = 1'b0;
    acc_done  = 1'b0;
    case (state)
      IDLE: if (have_cand && !flush) begin
        pop = 1'b1;
        if (cand_mis) begin
          start_exc = 1'b1;
          state_nxt = RESPOND;
        end else begin
          start_acc = 1'b1;
          state_nxt = ACCESS;
        end
      end
      // A flushed access still finishes on the bus; inflight=0 marks it as dropped.
      ACCESS: if (!dmem_busy) begin
        acc_done  = 1'b1;
        state_nxt = (flush || !inflight) ? IDLE : RESPOND;
      end
      RESPOND: if (flush || cpl_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) q_mem[wr_ptr] <= inc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      dmem_addr    <= '0;
      dmem_ren     <= 1'b0;
      dmem_wen     <= 1'b0;
      dmem_wdata   <= '0;
      dmem_byte_en <= '0;
      cur_store    <= 1'b0;
      cur_wen      <= 1'b0;
      cur_ltype    <= '0;
      cur_off      <= '0;
      cur_rd       <= '0;
      cur_index    <= '0;
      cpl_valid    <= 1'b0;
      cpl_index    <= '0;
      cpl_rd       <= '0;
      cpl_wen      <= 1'b0;
      cpl_data     <= '0;
      cpl_exc      <= 1'b0;
      cpl_cause    <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        count <= count + {1'b0, push} - {1'b0, pop};
      end

      if (flush)                              inflight <= 1'b0;
      else if (pop)                           inflight <= 1'b1;
      else if (state == RESPOND && cpl_ready) inflight <= 1'b0;

      if (start_acc) begin
        dmem_addr    <= {cand.addr[31:2], 2'b00};
        dmem_ren     <= !cand.store;
        dmem_wen     <= cand.store;
        dmem_wdata   <= cand_wd;
        dmem_byte_en <= cand_be;
      end else if (acc_done) begin
        dmem_addr    <= '0;
        dmem_ren     <= 1'b0;
        dmem_wen     <= 1'b0;
        dmem_wdata   <= '0;
        dmem_byte_en <= '0;
      end

      if (pop) begin
        cur_store <= cand.store;
        cur_wen   <= cand.wen;
        cur_ltype <= cand.ltype;
        cur_off   <= cand.addr[1:0];
        cur_rd    <= cand.rd;
        cur_index <= cand.index;
      end

      if (start_exc) begin
        cpl_valid <= 1'b1;
        cpl_index <= cand.index;
        cpl_rd    <= cand.rd;
        cpl_wen   <= 1'b0;
        cpl_data  <= '0;
        cpl_exc   <= 1'b1;
        cpl_cause <= cand.store ? 4'd6 : 4'd4;
      end else if (acc_done && state_nxt == RESPOND) begin
        cpl_valid <= 1'b1;
        cpl_index <= cur_index;
        cpl_rd    <= cur_rd;
        cpl_wen   <= cur_wen && !cur_store;
        cpl_data  <= cur_store ? 32'd0 : ld_data;
        cpl_exc   <= 1'b0;
        cpl_cause <= '0;
      end else if (state == RESPOND && state_nxt == IDLE) begin
        cpl_valid <= 1'b0;
        cpl_index <= '0;
        cpl_rd    <= '0;
        cpl_wen   <= 1'b0;
        cpl_data  <= '0;
        cpl_exc   <= 1'b0;
        cpl_cause <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer: directed corner cases plus a randomized run scored
// against a transaction-level model (expected bus ops and completions in accept order).
module tb_lsu_mem_sequencer;
  localparam int IDXW = 4;
`ifdef LSU_SKID_QUEUE_EN
  localparam int Q = 2;
`else
  localparam int Q = 1;
`endif

  logic            CLK = 1'b0;
  logic            RST;
  logic            req_valid, req_ready;
  logic [31:0]     req_addr, req_wdata;
  logic            req_dren, req_dwen;
  logic [2:0]      req_load_type;
  logic [4:0]      req_rd;
  logic            req_wen;
  logic [IDXW-1:0] req_index;
  logic            flush;
  logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
  logic            dmem_ren, dmem_wen, dmem_busy;
  logic [3:0]      dmem_byte_en;
  logic            cpl_valid, cpl_ready;
  logic [IDXW-1:0] cpl_index;
  logic [4:0]      cpl_rd;
  logic            cpl_wen, cpl_exc;
  logic [31:0]     cpl_data;
  logic [3:0]      cpl_cause;

  lsu_mem_sequencer #(.NUM_CB_ENTRY(16)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_dren(req_dren), .req_dwen(req_dwen), .req_load_type(req_load_type),
    .req_rd(req_rd), .req_wen(req_wen), .req_index(req_index), .flush(flush),
    .dmem_addr(dmem_addr), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
    .dmem_byte_en(dmem_byte_en), .dmem_rdata(dmem_rdata), .dmem_busy(dmem_busy),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_index(cpl_index), .cpl_rd(cpl_rd),
    .cpl_wen(cpl_wen), .cpl_data(cpl_data), .cpl_exc(cpl_exc), .cpl_cause(cpl_cause)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Bus memory model: fixed word pattern per address unless a directed test overrides it.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction
  logic        force_en;
  logic [31:0] force_val;
  assign dmem_rdata = force_en ? force_val : memf(dmem_addr);

  typedef struct {
    logic [IDXW-1:0] index;
    logic [4:0]      rd;
    logic            wen;
    logic [31:0]     data;
    logic            exc;
    logic [3:0]      cause;
  } cpl_t;
  typedef struct {
    logic [31:0] addr;
    logic        st;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  cpl_t exp_q[$];
  acc_t acc_q[$];
  int   occ = 0;
  logic sb_en = 1'b0;

  task automatic model_accept();
    int n, off;
    logic st;
    logic [31:0] v;
    cpl_t c;
    acc_t a;
    st  = req_dwen && !req_dren;
    n   = (req_load_type[1:0] == 2'd0) ? 1 : (req_load_type[1:0] == 2'd1) ? 2 : 4;
    off = int'(req_addr[1:0]);
    c.index = req_index;
    c.rd    = req_rd;
    if (off % n != 0) begin
      c.exc = 1'b1; c.cause = st ? 4'd6 : 4'd4; c.wen = 1'b0; c.data = 32'd0;
    end else begin
      c.exc = 1'b0; c.cause = 4'd0; c.wen = st ? 1'b0 : req_wen;
      v = memf(req_addr) >> (8 * off);
      if (n == 1) begin
        v = v & 32'hFF;
        if (!req_load_type[2] && v >= 32'd128) v = v - 32'd256;
      end else if (n == 2) begin
        v = v & 32'hFFFF;
        if (!req_load_type[2] && v >= 32'd32768) v = v - 32'd65536;
      end
      c.data  = st ? 32'd0 : v;
      a.addr  = req_addr - 32'(off);
      a.st    = st;
      a.be    = 4'(((1 << n) - 1) << off);
      a.wdata = (n == 1) ? {24'b0, req_wdata[7:0]} * 32'h0101_0101
              : (n == 2) ? {16'b0, req_wdata[15:0]} * 32'h0001_0001 : req_wdata;
      acc_q.push_back(a);
    end
    exp_q.push_back(c);
    occ++;
  endtask

  logic [IDXW+42:0] cvec, cvec_prev;
  logic [69:0]      bvec, bvec_prev;
  logic             hold_c = 1'b0, hold_b = 1'b0;
  assign cvec = {cpl_index, cpl_rd, cpl_wen, cpl_data, cpl_exc, cpl_cause};
  assign bvec = {dmem_addr, dmem_ren, dmem_wen, dmem_wdata, dmem_byte_en};

  acc_t ma;
  cpl_t mc;
  always @(negedge CLK) begin
    if (sb_en && !RST) begin
      chk("ready_vs_occupancy", 32'(req_ready), 32'(occ < Q));
      if (hold_c) chk("cpl_stable", 32'(cvec == cvec_prev), 32'd1);
      if (hold_b) chk("bus_stable", 32'(bvec == bvec_prev), 32'd1);
      if (req_valid && req_ready) model_accept();
      if ((dmem_ren || dmem_wen) && !dmem_busy) begin
        if (acc_q.size() == 0) chk("bus_op_without_request", 32'({dmem_ren, dmem_wen}), 32'd0);
        else begin
          ma = acc_q.pop_front();
          chk("bus_addr", dmem_addr, ma.addr);
          chk("bus_byte_en", 32'(dmem_byte_en), 32'(ma.be));
          chk("bus_kind", 32'({dmem_ren, dmem_wen}), ma.st ? 32'd1 : 32'd2);
          if (ma.st) chk("bus_wdata", dmem_wdata, ma.wdata);
        end
      end
      if (cpl_valid && cpl_ready) begin
        if (exp_q.size() == 0) chk("cpl_without_request", 32'(cpl_valid), 32'd0);
        else begin
          mc = exp_q.pop_front();
          occ--;
          chk("cpl_index", 32'(cpl_index), 32'(mc.index));
          chk("cpl_rd", 32'(cpl_rd), 32'(mc.rd));
          chk("cpl_wen", 32'(cpl_wen), 32'(mc.wen));
          chk("cpl_exc", 32'(cpl_exc), 32'(mc.exc));
          chk("cpl_cause", 32'(cpl_cause), 32'(mc.cause));
          if (!mc.exc) chk("cpl_data", cpl_data, mc.data);
        end
      end
      hold_c    = cpl_valid && !cpl_ready;
      cvec_prev = cvec;
      hold_b    = (dmem_ren || dmem_wen) && dmem_busy;
      bvec_prev = bvec;
    end else begin
      hold_c = 1'b0;
      hold_b = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one request; returns in the cycle after it was accepted.
  task automatic send(input logic [2:0] lt, input logic st, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] rd, input logic [IDXW-1:0] ix);
    int n = 0;
    req_valid = 1'b1; req_load_type = lt; req_dwen = st; req_dren = !st;
    req_addr = a; req_wdata = wd; req_rd = rd; req_wen = 1'b1; req_index = ix;
    while (!req_ready && n < 20) begin tick(); n++; end
    chk("send_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_cpl(input string tag, output logic saw_bus);
    int n = 0;
    saw_bus = dmem_ren || dmem_wen;
    while (!cpl_valid && n < 20) begin
      tick(); n++;
      if (dmem_ren || dmem_wen) saw_bus = 1'b1;
    end
    chk({tag, "_cpl_timeout"}, 32'(cpl_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sb;
    int nwen, bad;
    RST = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_dren = 1'b0; req_dwen = 1'b0;
    req_load_type = '0; req_rd = '0; req_wen = 1'b0; req_index = '0; flush = 1'b0;
    dmem_busy = 1'b0; cpl_ready = 1'b1; force_en = 1'b0; force_val = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_bus_en", 32'({dmem_ren, dmem_wen}), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_be", 32'(dmem_byte_en), 32'd0);
    chk("rst_cpl", 32'({cpl_valid, cpl_wen, cpl_exc, cpl_cause, cpl_rd, cpl_index}), 32'd0);
    chk("rst_cpl_data", cpl_data, 32'd0);
    RST = 1'b0;
    tick();

    // LW latency and field echo
    force_en = 1'b1; force_val = 32'hDEAD_BEEF;
    send(3'd2, 1'b0, 32'h100, 32'd0, 5'd7, 4'd3);
    chk("lw_ren_n1", 32'({dmem_ren, dmem_wen}), 32'd2);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_be", 32'(dmem_byte_en), 32'hF);
    chk("lw_ready_n1", 32'(req_ready), 32'(Q > 1));
    tick();
    chk("lw_cpl_n2", 32'(cpl_valid), 32'd1);
    chk("lw_data", cpl_data, 32'hDEAD_BEEF);
    chk("lw_index", 32'(cpl_index), 32'd3);
    chk("lw_rd_wen", 32'({cpl_rd, cpl_wen, cpl_exc}), 32'({5'd7, 1'b1, 1'b0}));
    chk("lw_ready_n2", 32'(req_ready), 32'(Q > 1));
    tick();
    chk("lw_cpl_drop", 32'(cpl_valid), 32'd0);
    chk("lw_ready_n3", 32'(req_ready), 32'd1);

    // LB / LBU lane select and extension
    force_val = 32'h8012_3456;
    send(3'd0, 1'b0, 32'h103, 32'd0, 5'd1, 4'd5);
    chk("lb_be", 32'(dmem_byte_en), 32'h8);
    tick();
    chk("lb_data", cpl_data, 32'hFFFF_FF80);
    tick();
    send(3'd4, 1'b0, 32'h103, 32'd0, 5'd1, 4'd6);
    tick();
    chk("lbu_data", cpl_data, 32'h0000_0080);
    tick();
    force_en = 1'b0;

    // SH with busy for three cycles
    dmem_busy = 1'b1;
    send(3'd1, 1'b1, 32'h202, 32'h0000_ABCD, 5'd2, 4'd7);
    chk("sh_be", 32'(dmem_byte_en), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    nwen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) dmem_busy = 1'b0;
      if (dmem_wen) nwen++;
      if (cpl_valid) break;
      tick();
    end
    chk("sh_wen_cycles", 32'(nwen), 32'd4);
    chk("sh_cpl", 32'({cpl_valid, cpl_wen, cpl_exc}), 32'b100);
    chk("sh_data", cpl_data, 32'd0);
    tick();

    // misaligned accesses
    send(3'd2, 1'b0, 32'h101, 32'd0, 5'd3, 4'd8);
    wait_cpl("lw_mis", sb);
    chk("lw_mis_nobus", 32'(sb), 32'd0);
    chk("lw_mis_exc", 32'({cpl_exc, cpl_wen}), 32'b10);
    chk("lw_mis_cause", 32'(cpl_cause), 32'd4);
    tick();
    send(3'd2, 1'b1, 32'h102, 32'd0, 5'd3, 4'd9);
    wait_cpl("sw_mis", sb);
    chk("sw_mis_nobus", 32'(sb), 32'd0);
    chk("sw_mis_cause", 32'(cpl_cause), 32'd6);
    tick();

`ifdef LSU_SKID_QUEUE_EN
    // two back-to-back with completions held
    cpl_ready = 1'b0;
    send(3'd2, 1'b0, 32'h400, 32'd0, 5'd4, 4'd1);
    send(3'd2, 1'b0, 32'h408, 32'd0, 5'd5, 4'd2);
    chk("skid_ready_drop", 32'(req_ready), 32'd0);
    repeat (3) tick();
    chk("skid_ready_held", 32'(req_ready), 32'd0);
    cpl_ready = 1'b1;
    wait_cpl("skid_a", sb);
    chk("skid_a_index", 32'(cpl_index), 32'd1);
    chk("skid_a_data", cpl_data, memf(32'h400));
    tick();
    wait_cpl("skid_b", sb);
    chk("skid_b_index", 32'(cpl_index), 32'd2);
    chk("skid_b_data", cpl_data, memf(32'h408));
    tick();
`endif

    // flush during a stalled access
    dmem_busy = 1'b1;
    send(3'd2, 1'b0, 32'h300, 32'd0, 5'd6, 4'd10);
`ifdef LSU_SKID_QUEUE_EN
    send(3'd2, 1'b0, 32'h304, 32'd0, 5'd6, 4'd11);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_bus_held", 32'(dmem_ren), 32'd1);
    chk("flush_ready", 32'(req_ready), 32'd1);
    dmem_busy = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpl_valid || dmem_ren || dmem_wen) bad++;
      tick();
    end
    chk("flush_no_activity", 32'(bad), 32'd0);
    chk("flush_ready_after", 32'(req_ready), 32'd1);

    // reset in the middle of an access
    dmem_busy = 1'b1;
    send(3'd2, 1'b0, 32'h500, 32'd0, 5'd1, 4'd1);
    chk("midrst_ren", 32'(dmem_ren), 32'd1);
    RST = 1'b1;
    tick();
    chk("midrst_bus", 32'({dmem_ren, dmem_wen, cpl_valid}), 32'd0);
    chk("midrst_addr", dmem_addr, 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    RST = 1'b0;
    dmem_busy = 1'b0;
    tick();

    // randomized traffic against the model
    sb_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic st;
      int n, low;
      st = ($urandom_range(0, 3) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_dwen  = st;
      req_dren  = !st || ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, st ? 2 : 4))
        0: req_load_type = 3'd0;
        1: req_load_type = 3'd1;
        2: req_load_type = 3'd2;
        3: req_load_type = 3'd4;
        default: req_load_type = 3'd5;
      endcase
      n   = (req_load_type[1:0] == 2'd0) ? 1 : (req_load_type[1:0] == 2'd1) ? 2 : 4;
      low = $urandom_range(0, 3);
      if ($urandom_range(0, 2) != 0) low = low & ~(n - 1);
      req_addr  = 32'h1000 | ($urandom & 32'h3FC) | 32'(low);
      req_wdata = $urandom;
      req_rd    = 5'($urandom);
      req_wen   = 1'($urandom);
      req_index = IDXW'($urandom);
      dmem_busy = ($urandom_range(0, 3) == 0);
      cpl_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0; dmem_busy = 1'b0; cpl_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_bus_empty", 32'(acc_q.size()), 32'd0);
    sb_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
